// File: rtl/memory_load_sequencer.sv
// Multicycle load sequencer feeding the load-size extension unit: issues a word-aligned
// read, waits MEM_LATENCY cycles, captures a lane-shifted word. Optional: LOAD_ALIGN_CHECK_EN.
module memory_load_sequencer #(
    parameter int unsigned MEM_LATENCY = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        load_request,
    input  logic [1:0]  load_size,
    input  logic [31:0] load_address,
    output logic [31:0] mem_address,
    output logic        mem_read,
    input  logic [31:0] mem_data_in,
    output logic [31:0] mdr_data,
    output logic [1:0]  load_size_ctrl,
    output logic        load_busy,
    output logic        load_done,
    output logic        load_fault
);

    localparam int unsigned CNT_W = 4;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_ISSUE = 3'd1,
        S_WAIT  = 3'd2,
`ifdef LOAD_ALIGN_CHECK_EN
        S_FAULT = 3'd4,
`endif
        S_DONE  = 3'd3
    } state_t;

    state_t             state_q;
    state_t             state_d;
    logic [CNT_W-1:0]   cnt_q;
    logic [1:0]         addr_lo_q;
    logic               accept_c;
    logic               capture_c;
    logic               reject_c;
    logic [31:0]        shifted_c;

    assign accept_c  = (state_q == S_IDLE) && load_request;
    assign capture_c = (state_q == S_WAIT) && (cnt_q == CNT_W'(1));

    // Misalignment and illegal-size detection on the incoming request
`ifdef LOAD_ALIGN_CHECK_EN
    always_comb begin
        reject_c = 1'b0;
        case (load_size)
            2'b00:   reject_c = (load_address[1:0] != 2'b00);
            2'b01:   reject_c = load_address[0];
            2'b10:   reject_c = 1'b0;
            default: reject_c = 1'b1;
        endcase
    end
`else
    assign reject_c = 1'b0;
`endif

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state_q <= S_IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (load_request) begin
`ifdef LOAD_ALIGN_CHECK_EN
                    state_d = reject_c ? S_FAULT : S_ISSUE;
`else
                    state_d = S_ISSUE;
`endif
                end
            end
            S_ISSUE: state_d = S_WAIT;
            S_WAIT:  if (cnt_q == CNT_W'(1)) state_d = S_DONE;
            S_DONE:  state_d = S_IDLE;
`ifdef LOAD_ALIGN_CHECK_EN
            S_FAULT: state_d = S_IDLE;
`endif
            default: state_d = S_IDLE;
        endcase
    end

    // Right-justify the addressed lane; upper bits are masked downstream
    always_comb begin
        shifted_c = mem_data_in;
        case (load_size_ctrl)
            2'b10:   shifted_c = mem_data_in >> {addr_lo_q, 3'b000};
            2'b01:   shifted_c = mem_data_in >> {addr_lo_q[1], 4'b0000};
            default: shifted_c = mem_data_in;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            mem_read       <= 1'b0;
            load_busy      <= 1'b0;
            load_done      <= 1'b0;
            mem_address    <= 32'd0;
            addr_lo_q      <= 2'b00;
            load_size_ctrl <= 2'b00;
            cnt_q          <= '0;
            mdr_data       <= 32'd0;
        end else begin
            mem_read  <= (state_d == S_ISSUE);
            load_busy <= (state_d != S_IDLE);
            load_done <= (state_d == S_DONE);
            if (accept_c) begin
                mem_address    <= {load_address[31:2], 2'b00};
                addr_lo_q      <= load_address[1:0];
                load_size_ctrl <= load_size;
            end
            if (state_q == S_ISSUE)     cnt_q <= CNT_W'(MEM_LATENCY);
            else if (state_q == S_WAIT) cnt_q <= cnt_q - CNT_W'(1);
            if (capture_c) mdr_data <= shifted_c;
        end
    end

    // Fault pulse trails the FAULT state by one cycle
`ifdef LOAD_ALIGN_CHECK_EN
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) load_fault <= 1'b0;
        else        load_fault <= (state_q == S_FAULT);
    end
`else
    assign load_fault = 1'b0;
`endif

endmodule

// File: tb/tb_memory_load_sequencer.sv
// Directed bench for memory_load_sequencer at MEM_LATENCY 1 and 3; honours LOAD_ALIGN_CHECK_EN.
module tb_memory_load_sequencer;

    logic        clk = 1'b0;
    logic        reset;
    logic        req1, req3;
    logic [1:0]  load_size;
    logic [31:0] load_address;
    logic [31:0] mem_data_in;

    logic [31:0] mem_address1, mdr1, mem_address3, mdr3;
    logic [1:0]  ctrl1, ctrl3;
    logic        mem_read1, busy1, done1, fault1;
    logic        mem_read3, busy3, done3, fault3;

    int n_checks = 0;
    int n_fails  = 0;

    always #5 clk = ~clk;

    memory_load_sequencer #(.MEM_LATENCY(1)) dut1 (
        .clk(clk), .reset(reset), .load_request(req1), .load_size(load_size),
        .load_address(load_address), .mem_address(mem_address1), .mem_read(mem_read1),
        .mem_data_in(mem_data_in), .mdr_data(mdr1), .load_size_ctrl(ctrl1),
        .load_busy(busy1), .load_done(done1), .load_fault(fault1)
    );

    memory_load_sequencer #(.MEM_LATENCY(3)) dut3 (
        .clk(clk), .reset(reset), .load_request(req3), .load_size(load_size),
        .load_address(load_address), .mem_address(mem_address3), .mem_read(mem_read3),
        .mem_data_in(mem_data_in), .mdr_data(mdr3), .load_size_ctrl(ctrl3),
        .load_busy(busy3), .load_done(done3), .load_fault(fault3)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        assert (got === exp) else begin
            n_fails++;
            $error("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Latency-1 load: request sampled at the next edge, done two edges later
    task automatic load_l1(input logic [31:0] addr, input logic [1:0] size, input logic [31:0] data,
                           input logic [31:0] exp_mdr, input logic [31:0] exp_maddr);
        load_address = addr;
        load_size    = size;
        mem_data_in  = data;
        req1 = 1'b1;
        tick();
        req1 = 1'b0;
        chk("l1_mem_read_issue", mem_read1, 1);
        chk("l1_mem_address", mem_address1, exp_maddr);
        chk("l1_busy_issue", busy1, 1);
        tick();
        chk("l1_mem_read_wait", mem_read1, 0);
        chk("l1_done_wait", done1, 0);
        tick();
        chk("l1_done", done1, 1);
        chk("l1_mdr", mdr1, exp_mdr);
        chk("l1_size_ctrl", ctrl1, 32'(size));
        chk("l1_fault_quiet", fault1, 0);
        tick();
        chk("l1_done_drop", done1, 0);
        chk("l1_busy_drop", busy1, 0);
    endtask

`ifdef LOAD_ALIGN_CHECK_EN
    task automatic fault_l1(input logic [31:0] addr, input logic [1:0] size, input logic [31:0] exp_mdr);
        load_address = addr;
        load_size    = size;
        req1 = 1'b1;
        tick();
        req1 = 1'b0;
        chk("flt_no_read", mem_read1, 0);
        chk("flt_pulse_not_yet", fault1, 0);
        chk("flt_busy", busy1, 1);
        tick();
        chk("flt_pulse", fault1, 1);
        chk("flt_no_read2", mem_read1, 0);
        chk("flt_no_done", done1, 0);
        chk("flt_mdr_kept", mdr1, exp_mdr);
    endtask
`endif

    initial begin
        reset = 1'b0;
        req1 = 1'b0;
        req3 = 1'b0;
        load_size = 2'b00;
        load_address = 32'd0;
        mem_data_in = 32'd0;

        #3;
        chk("rst_mem_read", mem_read1, 0);
        chk("rst_mdr", mdr1, 0);
        chk("rst_maddr", mem_address3, 0);
        chk("rst_busy", busy3, 0);
        chk("rst_done", done1, 0);
        chk("rst_fault", fault1, 0);
        chk("rst_ctrl", ctrl3, 0);
        tick();
        tick();
        #3 reset = 1'b1;
        tick();

        // Word load, latency 1
        load_l1(32'h0000_0010, 2'b00, 32'hDEAD_BEEF, 32'hDEAD_BEEF, 32'h0000_0010);

        // Byte lanes
        load_l1(32'h0000_0020, 2'b10, 32'h4433_2211, 32'h4433_2211, 32'h0000_0020);
        load_l1(32'h0000_0021, 2'b10, 32'h4433_2211, 32'h0044_3322, 32'h0000_0020);
        load_l1(32'h0000_0022, 2'b10, 32'h4433_2211, 32'h0000_4433, 32'h0000_0020);
        load_l1(32'h0000_0023, 2'b10, 32'h4433_2211, 32'h0000_0044, 32'h0000_0020);

`ifdef LOAD_ALIGN_CHECK_EN
        fault_l1(32'h0000_0013, 2'b00, 32'h0000_0044);
        fault_l1(32'h0000_0011, 2'b01, 32'h0000_0044);
        fault_l1(32'h0000_0020, 2'b11, 32'h0000_0044);
        // Accepted at the edge right after the fault pulse
        load_l1(32'h0000_0024, 2'b10, 32'hA1B2_C3D4, 32'hA1B2_C3D4, 32'h0000_0024);
`else
        load_l1(32'h0000_0013, 2'b00, 32'h89AB_CDEF, 32'h89AB_CDEF, 32'h0000_0010);
        load_l1(32'h0000_0022, 2'b11, 32'h89AB_CDEF, 32'h89AB_CDEF, 32'h0000_0020);
        chk("nofault_pin", fault1, 0);
`endif

        // Halfword, latency 3, request held high across busy
        load_address = 32'h0000_0032;
        load_size    = 2'b01;
        mem_data_in  = 32'hCAFE_1234;
        req3 = 1'b1;
        tick();
        chk("h3_mem_read", mem_read3, 1);
        chk("h3_maddr", mem_address3, 32'h0000_0030);
        for (int i = 1; i <= 3; i++) begin
            tick();
            chk("h3_wait_busy", busy3, 1);
            chk("h3_wait_no_done", done3, 0);
            chk("h3_wait_no_read", mem_read3, 0);
        end
        tick();
        chk("h3_done", done3, 1);
        chk("h3_mdr", mdr3, 32'h0000_CAFE);
        chk("h3_ctrl", ctrl3, 32'd1);
        tick();
        chk("h3_done_drop", done3, 0);
        chk("h3_idle", busy3, 0);
        chk("h3_no_early_read", mem_read3, 0);
        tick();
        req3 = 1'b0;
        chk("h3_reaccept_edge6", mem_read3, 1);
        for (int i = 7; i <= 9; i++) tick();
        tick();
        chk("h3_second_done", done3, 1);
        tick();
        chk("h3_second_idle", busy3, 0);

        // Reset during ISSUE drops mem_read immediately
        load_address = 32'h0000_0044;
        load_size    = 2'b00;
        req3 = 1'b1;
        tick();
        req3 = 1'b0;
        chk("ri_mem_read_up", mem_read3, 1);
        #2 reset = 1'b0;
        #1;
        chk("ri_mem_read_drop", mem_read3, 0);
        chk("ri_maddr", mem_address3, 0);
        chk("ri_busy", busy3, 0);
        reset = 1'b1;
        tick();

        // Reset mid-WAIT aborts and clears MDR
        load_address = 32'h0000_0040;
        load_size    = 2'b00;
        mem_data_in  = 32'h1234_5678;
        req3 = 1'b1;
        tick();
        req3 = 1'b0;
        tick();
        tick();
        chk("rw_busy_before", busy3, 1);
        #2 reset = 1'b0;
        #1;
        chk("rw_mdr", mdr3, 0);
        chk("rw_maddr", mem_address3, 0);
        chk("rw_ctrl", ctrl3, 0);
        chk("rw_busy", busy3, 0);
        chk("rw_done", done3, 0);
        chk("rw_read", mem_read3, 0);
        tick();
        tick();
        #2 reset = 1'b1;
        for (int i = 0; i < 6; i++) begin
            tick();
            chk("rw_no_done", done3, 0);
        end

        // Fresh load after reset release
        load_address = 32'h0000_0041;
        load_size    = 2'b10;
        req3 = 1'b1;
        tick();
        req3 = 1'b0;
        chk("pr_mem_read", mem_read3, 1);
        chk("pr_maddr", mem_address3, 32'h0000_0040);
        tick();
        tick();
        tick();
        chk("pr_not_done_yet", done3, 0);
        tick();
        chk("pr_done", done3, 1);
        chk("pr_mdr", mdr3, 32'h0012_3456);
        tick();
        chk("pr_done_drop", done3, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
